wishbone_slave_mem: RTL and testbench
=====================================

# wishbone_slave_mem

Single-port Wishbone slave memory sitting directly downstream of the single-master Wishbone controller. It receives the master's registered cyc/stb/we/addr/data/sel/cti outputs and answers each strobe with exactly one registered ack or err. Requests can be given programmable wait states. Beats following an acknowledged burst beat (CTI 001/010) skip the wait states. It is the default target for single-slave bring-up and regression.

## Interface
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width (multiple of 8)
- SEL_WIDTH, DATA_WIDTH/8, byte-select width
- DEPTH, 256, number of DATA_WIDTH words (power of two)
- BASE_ADDR, 0, byte address of word 0 (DEPTH*SEL_WIDTH aligned)
- WAIT_CYCLES, 1, wait states inserted before ack on a non-burst request (0..15)

- clk_i  in  1  single clock; all logic on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- cyc_i  in  1  bus cycle valid
- stb_i  in  1  transfer strobe
- we_i  in  1  1 = write, 0 = read
- addr_i  in  ADDR_WIDTH  byte address
- data_i  in  DATA_WIDTH  write data from master
- sel_i  in  SEL_WIDTH  byte-lane enables (writes only)
- cti_i  in  3  cycle type: 000 classic, 001 const, 010 incr, 111 end
- data_o  out  DATA_WIDTH  read data, registered
- ack_o  out  1  transfer acknowledge, registered, one-cycle pulse
- err_o  out  1  transfer error, registered, one-cycle pulse
- state_out  out  2  current FSM state (debug)

## Operation
- Request means `cyc_i & stb_i`. Offset is `addr_i - BASE_ADDR`.
- Hit condition, all three required:
  - `addr_i >= BASE_ADDR`
  - `offset < DEPTH*SEL_WIDTH`
  - `offset[log2(SEL_WIDTH)-1:0] == 0`
- Word index is `offset >> log2(SEL_WIDTH)`. Anything other than a hit is a miss.
- States and encoding: IDLE=00, WAIT=01, ACK=10, HOLD=11.
- IDLE:
  - Request with burst_flag=1 or WAIT_CYCLES=0 -> ACK.
  - Request otherwise -> WAIT, with cnt loaded to WAIT_CYCLES-1.
- WAIT:
  - cyc_i or stb_i low -> IDLE. The request is aborted: no memory access, no ack/err.
  - cnt==0 -> ACK; otherwise cnt decrements.
- Commit: on the edge entering ACK, inputs sampled at that edge decide the response.
  - Hit, write: byte lane i of mem[index] <= data_i lane i for each sel_i[i]=1. sel_i=0 still acks with memory unchanged. ack_o<=1, data_o<=0.
  - Hit, read: data_o<=mem[index] (full word, sel_i ignored), ack_o<=1.
  - Miss: err_o<=1, data_o<=0, no memory access.
  - burst_flag is set if the committed cti_i is 001 or 010 and the transfer hit. It is cleared on cti 000/111 or on a miss.
- ACK: ack_o/err_o are high for exactly this cycle. Next state is HOLD if stb_i=1, else IDLE.
- HOLD: waits for the master to drop the strobe; never re-acks. stb_i=0 or cyc_i=0 -> IDLE.
- burst_flag is also cleared in any state when cyc_i=0.
- data_o holds its value outside commit edges.
- ack_o and err_o are never high together.

## Timing
- Reset (rst_ni=0, asynchronous): state=IDLE, cnt=0, burst_flag=0, ack_o=0, err_o=0, data_o=0, state_out=00.
- Memory contents are not reset. Benches write before reading.
- Deassertion is synchronised by the integrator; the block needs no recovery cycle.
- Latency: request seen in IDLE during cycle k -> ack_o/err_o high in cycle k+1+WAIT_CYCLES.
- Burst fast path: ack in cycle k+1 when burst_flag=1.
- Minimum spacing between acks is 2 cycles (ACK then IDLE/HOLD).
- Reset asserted in WAIT or ACK: the transfer is lost, with no ack and no write. A write is already complete if its commit edge preceded reset.
- Request dropped on the same edge WAIT would reach cnt==0: abort wins, so no commit.
- Simultaneous cyc_i=0 with a commit: the commit occurs from the sampled inputs only if stb_i/cyc_i were high at the entering edge. Otherwise the request is aborted.

## Test plan
- Reset, then WAIT_CYCLES=1: write addr 0x10, data 0xA5A5_1234, sel 1111, cti 000 -> ack_o in cycle k+2, one cycle wide, state_out 00->01->10->11/00. Read 0x10 -> data_o=0xA5A5_1234 with ack_o.
- Byte lanes: write 0xFFFF_FFFF to 0x20, then write 0x0000_0000 with sel 0101 -> read returns 0xFF00_FF00. sel 0000 write -> ack, contents unchanged.
- Errors: address DEPTH*4 (0x400), address 0x13 (misaligned), and address below BASE_ADDR=0x1000 -> err_o pulse, ack_o=0, data_o=0, memory unchanged.
- Incrementing burst of 4 reads at 0x40.. with cti 010,010,010,111, WAIT_CYCLES=3 -> first ack at k+4, later beats at k+1 of each strobe. After cti 111, a classic request waits 3 cycles again.
- Abort: request, drop stb_i in WAIT -> no ack/err, no write (a follow-up read shows the old value). Hold stb_i high 5 cycles after ack -> exactly one ack, state stays 11 until stb_i drops.
- Reset mid-WAIT on a write -> all outputs 0 at once, target word unchanged afterwards.

Source files
------------

// File: rtl/wishbone_slave_mem.sv
// Wishbone slave word memory with programmable wait states and a burst fast path; one registered ack/err per strobe.
// Latency 1+WAIT_CYCLES cycles (1 on a continued burst); the strobe must drop before the next request is served.
module wishbone_slave_mem #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    SEL_WIDTH   = DATA_WIDTH / 8,
    parameter int                    DEPTH       = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_CYCLES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    input  logic [2:0]            cti_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [1:0]            state_out
);

    localparam int LSB   = $clog2(SEL_WIDTH);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0]   SPAN       = (ADDR_WIDTH+1)'(DEPTH * SEL_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(SEL_WIDTH - 1);
    localparam logic [3:0]            WAIT_INIT  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_ACK  = 2'b10,
        S_HOLD = 2'b11
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    burst_q;
    logic                    commit;
    logic                    req;
    logic                    hit;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    ack_q, err_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign req    = cyc_i & stb_i;
    assign offset = addr_i - BASE_ADDR;
    assign hit    = (addr_i >= BASE_ADDR) && ({1'b0, offset} < SPAN) && ((offset & ALIGN_MASK) == '0);
    assign idx    = offset[LSB +: IDX_W];

    // commit marks the edge entering ACK; every response and write is decided from inputs seen there
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (burst_q || (WAIT_CYCLES == 0)) begin
                        state_d = S_ACK;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK:   state_d = stb_i ? S_HOLD : S_IDLE;
            S_HOLD:  if (!req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            burst_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= commit & hit;
            err_q   <= commit & ~hit;
            if (commit) begin
                data_q <= (hit && !we_i) ? mem[idx] : '0;
            end
            if (!cyc_i) begin
                burst_q <= 1'b0;
            end else if (commit) begin
                burst_q <= hit && ((cti_i == 3'b001) || (cti_i == 3'b010));
            end
        end
    end

    // storage is deliberately left out of reset
    always_ff @(posedge clk_i) begin
        if (commit && hit && we_i) begin
            for (int i = 0; i < SEL_WIDTH; i++) begin
                if (sel_i[i]) mem[idx][i*8 +: 8] <= data_i[i*8 +: 8];
            end
        end
    end

    assign data_o    = data_q;
    assign ack_o     = ack_q;
    assign err_o     = err_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_wishbone_slave_mem.sv
// Bench for wishbone_slave_mem: one instance at base 0 with 1 wait state, one at base 0x1000 with 3 wait states.
// Expected responses are queued when a request is driven and popped when ack/err appears.
module tb_wishbone_slave_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [31:0] addr, wdat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    int          tgt;

    logic [31:0] d0, d1;
    logic        ack0, ack1, err0, err1;
    logic [1:0]  st0, st1;
    logic        cyc0, cyc1;

    typedef struct packed {
        logic        err;
        logic [31:0] dat;
    } exp_t;
    exp_t sb_q[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign cyc0 = cyc & (tgt == 0);
    assign cyc1 = cyc & (tgt == 1);

    wishbone_slave_mem #(.WAIT_CYCLES(1)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc0), .stb_i(stb), .we_i(we),
        .addr_i(addr), .data_i(wdat), .sel_i(sel), .cti_i(cti),
        .data_o(d0), .ack_o(ack0), .err_o(err0), .state_out(st0)
    );

    wishbone_slave_mem #(.BASE_ADDR(32'h1000), .WAIT_CYCLES(3)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc1), .stb_i(stb), .we_i(we),
        .addr_i(addr), .data_i(wdat), .sel_i(sel), .cti_i(cti),
        .data_o(d1), .ack_o(ack1), .err_o(err1), .state_out(st1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] cur_st(input int t);
        return (t == 1) ? st1 : st0;
    endfunction

    function automatic logic cur_resp(input int t);
        return (t == 1) ? (ack1 | err1) : (ack0 | err0);
    endfunction

    // response monitor: every ack/err must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && (ack0 | err0 | ack1 | err1)) begin
            exp_t e;
            chk("ack_err_excl", 64'((ack0 & err0) | (ack1 & err1)), 64'd0);
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_err", 64'(err0 | err1), 64'(e.err));
                chk("sb_dat", 64'((ack0 | err0) ? d0 : d1), 64'(e.dat));
            end
        end
    end

    task automatic xfer(input int t, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] c, input logic e_err,
                        input logic [31:0] e_dat, input int e_lat, input int hold, input logic keep);
        int   n;
        logic got;
        exp_t e;
        @(negedge clk);
        tgt = t; cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d; sel = s; cti = c;
        e.err = e_err;
        e.dat = e_dat;
        sb_q.push_back(e);
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = cur_resp(t);
            if (n == 1) chk("st_first", 64'(cur_st(t)), (e_lat == 1) ? 64'd2 : 64'd1);
        end
        chk("latency", 64'(n), 64'(e_lat));
        chk("st_ack", 64'(cur_st(t)), 64'd2);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("st_hold", 64'(cur_st(t)), 64'd3);
        end
        stb = 1'b0;
        cyc = keep;
        @(negedge clk);
        chk("st_after", 64'(cur_st(t)), 64'd0);
        chk("pulse_width", 64'(cur_resp(t)), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdat = '0; sel = '0; cti = '0; tgt = 0;
        repeat (2) @(negedge clk);
        chk("rst_st0", 64'(st0), 64'd0);
        chk("rst_st1", 64'(st1), 64'd0);
        chk("rst_resp", 64'(ack0 | err0 | ack1 | err1), 64'd0);
        chk("rst_dat", 64'(d0 | d1), 64'd0);
        rst_n = 1'b1;

        // basic write/read, 1 wait state
        xfer(0, 1, 32'h10, 32'hA5A5_1234, 4'hF, 3'b000, 0, 32'h0, 2, 0, 0);
        xfer(0, 0, 32'h10, 32'h0, 4'hF, 3'b000, 0, 32'hA5A5_1234, 2, 0, 0);

        // byte lanes
        xfer(0, 1, 32'h20, 32'hFFFF_FFFF, 4'hF, 3'b000, 0, 32'h0, 2, 0, 0);
        xfer(0, 1, 32'h20, 32'h0000_0000, 4'b0101, 3'b000, 0, 32'h0, 2, 0, 0);
        xfer(0, 0, 32'h20, 32'h0, 4'h0, 3'b000, 0, 32'hFF00_FF00, 2, 0, 0);
        xfer(0, 1, 32'h20, 32'h1234_5678, 4'h0, 3'b000, 0, 32'h0, 2, 0, 0);
        xfer(0, 0, 32'h20, 32'h0, 4'hF, 3'b000, 0, 32'hFF00_FF00, 2, 0, 0);

        // out of range and misaligned
        xfer(0, 1, 32'h0, 32'h1111_1111, 4'hF, 3'b000, 0, 32'h0, 2, 0, 0);
        xfer(0, 0, 32'h10, 32'h0, 4'hF, 3'b000, 0, 32'hA5A5_1234, 2, 0, 0);
        xfer(0, 0, 32'h400, 32'h0, 4'hF, 3'b000, 1, 32'h0, 2, 0, 0);
        xfer(0, 1, 32'h400, 32'h2222_2222, 4'hF, 3'b000, 1, 32'h0, 2, 0, 0);
        xfer(0, 1, 32'h13, 32'h3333_3333, 4'hF, 3'b000, 1, 32'h0, 2, 0, 0);
        xfer(0, 0, 32'h0, 32'h0, 4'hF, 3'b000, 0, 32'h1111_1111, 2, 0, 0);
        xfer(0, 0, 32'h10, 32'h0, 4'hF, 3'b000, 0, 32'hA5A5_1234, 2, 0, 0);

        // incrementing burst, 3 wait states
        for (int i = 0; i < 4; i++)
            xfer(1, 1, 32'h1040 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF, 3'b000, 0, 32'h0, 4, 0, 0);
        xfer(1, 0, 32'h1040, 32'h0, 4'hF, 3'b010, 0, 32'hB000_0000, 4, 0, 1);
        xfer(1, 0, 32'h1044, 32'h0, 4'hF, 3'b010, 0, 32'hB000_0001, 1, 0, 1);
        xfer(1, 0, 32'h1048, 32'h0, 4'hF, 3'b010, 0, 32'hB000_0002, 1, 0, 1);
        xfer(1, 0, 32'h104C, 32'h0, 4'hF, 3'b111, 0, 32'hB000_0003, 1, 0, 0);
        xfer(1, 0, 32'h1044, 32'h0, 4'hF, 3'b000, 0, 32'hB000_0001, 4, 0, 0);
        xfer(1, 0, 32'h0FFC, 32'h0, 4'hF, 3'b000, 1, 32'h0, 4, 0, 0);

        // abort: strobe dropped on the edge that would have committed
        @(negedge clk);
        tgt = 0; cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h10; wdat = 32'hDEAD_BEEF; sel = 4'hF; cti = 3'b000;
        @(negedge clk);
        chk("abort_wait", 64'(st0), 64'd1);
        cyc = 1'b0; stb = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_idle", 64'(st0), 64'd0);
        xfer(0, 0, 32'h10, 32'h0, 4'hF, 3'b000, 0, 32'hA5A5_1234, 2, 0, 0);

        // strobe held after ack
        xfer(0, 0, 32'h10, 32'h0, 4'hF, 3'b000, 0, 32'hA5A5_1234, 2, 5, 0);

        // reset during WAIT on a write
        @(negedge clk);
        tgt = 0; cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h10; wdat = 32'h0BAD_F00D; sel = 4'hF; cti = 3'b000;
        @(negedge clk);
        chk("rst_mid_wait", 64'(st0), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_st", 64'(st0), 64'd0);
        chk("rst_mid_resp", 64'(ack0 | err0), 64'd0);
        chk("rst_mid_dat", 64'(d0), 64'd0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; rst_n = 1'b1;
        xfer(0, 0, 32'h10, 32'h0, 4'hF, 3'b000, 0, 32'hA5A5_1234, 2, 0, 0);

        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
